// File: rtl/slot_credit_controller.sv
// ---------------------------------------------------------------------------
// slot_credit_controller
//
// Player-facing game controller for a three-reel slot machine. It debounces
// the spin button and charges a credit per spin. It then requests a spin from
// the reel logic and waits for the reels to stop. Finally it scores the
// stopped reel values and pays out into a two-digit BCD credit balance.
//
// Ports:
//   clock_in       system clock
//   CLR            asynchronous active-high reset
//   button         raw asynchronous spin push-button, active-high
//   reels_running  high while any reel is still spinning
//   reel1..reel3   stopped reel values (4 bits each)
//   spin_start     level request to the reel logic, high throughout START
//   credits_tens   BCD tens digit of the balance
//   credits_ones   BCD ones digit of the balance
//   win            last result: 0 none, 1 pair, 2 triple
//   busy           high whenever a spin is in progress
//   game_over      balance below spin cost while idle / game over
// ---------------------------------------------------------------------------
module slot_credit_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int START_TIMEOUT   = 100000000,
    parameter int START_CREDITS   = 10,
    parameter int SPIN_COST       = 1,
    parameter int PAIR_PAY        = 2,
    parameter int TRIPLE_PAY      = 10,
    parameter int MAX_CREDITS     = 99
) (
    input  logic       clock_in,
    input  logic       CLR,
    input  logic       button,
    input  logic       reels_running,
    input  logic [3:0] reel1,
    input  logic [3:0] reel2,
    input  logic [3:0] reel3,
    output logic       spin_start,
    output logic [3:0] credits_tens,
    output logic [3:0] credits_ones,
    output logic [1:0] win,
    output logic       busy,
    output logic       game_over
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W    = $clog2(START_TIMEOUT + 1);
    localparam int MAX_PAY = (TRIPLE_PAY > PAIR_PAY) ? TRIPLE_PAY : PAIR_PAY;
    localparam int PAY_W   = $clog2(MAX_PAY + 2);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TIMEOUT - 1);
    localparam logic [3:0]       RST_TENS = 4'(START_CREDITS / 10);
    localparam logic [3:0]       RST_ONES = 4'(START_CREDITS % 10);
    localparam logic [3:0]       COST     = 4'(SPIN_COST);
    localparam logic [6:0]       COST_BIN = 7'(SPIN_COST);
    localparam logic [6:0]       MAX_BIN  = 7'(MAX_CREDITS);
    localparam logic [PAY_W-1:0] PAY_TRI  = PAY_W'(TRIPLE_PAY);
    localparam logic [PAY_W-1:0] PAY_PAIR = PAY_W'(PAIR_PAY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHARGE,
        S_START,
        S_WAIT_STOP,
        S_EVAL,
        S_PAYOUT,
        S_GAME_OVER
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic [1:0]      sync_reg;       // [0] first stage, [1] synchronized bit
    logic            sync_last_reg;  // previous synchronized bit, for change detect
    logic [DB_W-1:0] db_cnt_reg;
    logic            stable_reg;
    logic            stable_d_reg;
    logic            press;

    always_ff @(posedge clock_in or posedge CLR) begin
        if (CLR) begin
            sync_reg      <= 2'b00;
            sync_last_reg <= 1'b0;
            db_cnt_reg    <= '0;
            stable_reg    <= 1'b0;
            stable_d_reg  <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], button};
            sync_last_reg <= sync_reg[1];
            stable_d_reg  <= stable_reg;
            // Any bounce restarts the stability window. Once the counter
            // saturates, the input has been steady long enough to accept.
            if (sync_reg[1] != sync_last_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg != DB_MAX) begin
                db_cnt_reg <= db_cnt_reg + DB_W'(1);
            end else begin
                stable_reg <= sync_last_reg;
            end
        end
    end

    // Single-cycle pulse on the accepted rising edge.
    assign press = stable_reg & ~stable_d_reg;

    // ------------------------------------------------------------------
    // Game FSM and credit datapath
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic [3:0]       tens_reg, tens_next;
    logic [3:0]       ones_reg, ones_next;
    logic [1:0]       win_reg, win_next;
    logic [PAY_W-1:0] pay_reg, pay_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             spin_start_reg;
    logic             busy_reg;
    logic [6:0]       bal_bin;

    // Binary view of the balance, used only for comparisons.
    assign bal_bin = (7'(tens_reg) * 7'd10) + 7'(ones_reg);

    always_comb begin
        state_next  = state_reg;
        tens_next   = tens_reg;
        ones_next   = ones_reg;
        win_next    = win_reg;
        pay_next    = pay_reg;
        to_cnt_next = to_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (press) begin
                    if (bal_bin >= COST_BIN) begin
                        state_next = S_CHARGE;
                    end else begin
                        state_next = S_GAME_OVER;
                    end
                end
            end

            S_CHARGE: begin
                // BCD subtract of a single-digit cost. The balance is known
                // to cover the cost, so a borrow always finds tens >= 1. The
                // 4-bit wrap in ones+10-cost is harmless: the result is < 10.
                if (ones_reg >= COST) begin
                    ones_next = ones_reg - COST;
                end else begin
                    ones_next = ones_reg + (4'd10 - COST);
                    tens_next = tens_reg - 4'd1;
                end
                win_next    = 2'd0;
                to_cnt_next = '0;
                state_next  = S_START;
            end

            S_START: begin
                // A missed reels_running rise should not hang the game.
                // After the timeout, score whatever the reels show.
                if (reels_running) begin
                    state_next = S_WAIT_STOP;
                end else if (to_cnt_reg == TO_LAST) begin
                    state_next = S_EVAL;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end

            S_WAIT_STOP: begin
                if (!reels_running) begin
                    state_next = S_EVAL;
                end
            end

            S_EVAL: begin
                // If not all three reels match, any single equality is
                // exactly one pair.
                if ((reel1 == reel2) && (reel2 == reel3)) begin
                    pay_next = PAY_TRI;
                    win_next = 2'd2;
                end else if ((reel1 == reel2) || (reel2 == reel3) || (reel1 == reel3)) begin
                    pay_next = PAY_PAIR;
                    win_next = 2'd1;
                end else begin
                    pay_next = '0;
                    win_next = 2'd0;
                end
                state_next = S_PAYOUT;
            end

            S_PAYOUT: begin
                // Count the pay in one credit per cycle. Whatever remains
                // after the balance hits the ceiling is forfeited.
                if ((pay_reg == '0) || (bal_bin >= MAX_BIN)) begin
                    pay_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    if (ones_reg == 4'd9) begin
                        ones_next = 4'd0;
                        tens_next = tens_reg + 4'd1;
                    end else begin
                        ones_next = ones_reg + 4'd1;
                    end
                    pay_next = pay_reg - PAY_W'(1);
                end
            end

            S_GAME_OVER: begin
                state_next = S_GAME_OVER;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge CLR) begin
        if (CLR) begin
            state_reg      <= S_IDLE;
            tens_reg       <= RST_TENS;
            ones_reg       <= RST_ONES;
            win_reg        <= 2'd0;
            pay_reg        <= '0;
            to_cnt_reg     <= '0;
            spin_start_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tens_reg       <= tens_next;
            ones_reg       <= ones_next;
            win_reg        <= win_next;
            pay_reg        <= pay_next;
            to_cnt_reg     <= to_cnt_next;
            // Outputs are registered from the next state. They line up
            // exactly with the state register and need no extra decode.
            spin_start_reg <= (state_next == S_START);
            busy_reg       <= (state_next != S_IDLE) && (state_next != S_GAME_OVER);
        end
    end

    assign spin_start   = spin_start_reg;
    assign busy         = busy_reg;
    assign credits_tens = tens_reg;
    assign credits_ones = ones_reg;
    assign win          = win_reg;
    assign game_over    = (bal_bin < COST_BIN) &&
                          ((state_reg == S_IDLE) || (state_reg == S_GAME_OVER));

endmodule
